// File: rtl/mmio_pkg.sv
// Shared constants for the subleq MMIO unit: offsets of the register block below
// the top of the address space, and the bit positions of the status word.
package mmio_pkg;

    localparam int HALT_OFS = 0;
    localparam int OUT_OFS  = 1;
    localparam int IN_OFS   = 2;
    localparam int STAT_OFS = 3;

    localparam int STAT_IN_NEMPTY = 0;
    localparam int STAT_OUT_NFULL = 1;
    localparam int STAT_IN_EOF    = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Full/empty come from the registered count only, so a push
// into a full FIFO is dropped even if the same cycle pops.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mmio_stream.sv
// Buffered MMIO unit for the subleq core: halt/output/input(/status) registers at the
// top of memory, backed by stream FIFOs. Define MMIO_STATUS_EN to map the status word.
module mmio_stream
    import mmio_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 load,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] data_out,
    output logic [WORD_SIZE-1:0] data_in,
    output logic                 stall,
    output logic                 halt,
    input  logic [WORD_SIZE-1:0] mem_out,
    output logic [WORD_SIZE-1:0] mem_in,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] addr_out,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_eof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data
);
    localparam logic [WORD_SIZE-1:0] TOP = '1;

    logic                 halt_q, halt_d;
    logic                 is_halt, is_out, is_in, is_stat, is_io;
    logic                 acc, in_rd, in_pop, in_push, out_wr, out_push, out_pop;
    logic                 in_full, in_empty, out_full, out_empty;
    logic [WORD_SIZE-1:0] in_head;

    assign is_halt = (addr == TOP - WORD_SIZE'(HALT_OFS));
    assign is_out  = (addr == TOP - WORD_SIZE'(OUT_OFS));
    assign is_in   = (addr == TOP - WORD_SIZE'(IN_OFS));
`ifdef MMIO_STATUS_EN
    assign is_stat = (addr == TOP - WORD_SIZE'(STAT_OFS));
`else
    assign is_stat = 1'b0;
`endif
    assign is_io = is_halt | is_out | is_in | is_stat;

    // Once halted the core is frozen out: no access has any side effect.
    assign acc      = req & ~halt_q;
    assign in_rd    = acc & load & is_in;
    assign in_pop   = in_rd & ~in_empty;
    assign out_wr   = acc & ~load & is_out;
    assign out_push = out_wr & ~out_full;
    assign in_push  = in_valid & in_ready;
    assign out_pop  = out_valid & out_ready;

    assign stall    = (in_rd & in_empty & ~in_eof) | (out_wr & out_full);
    assign halt_d   = halt_q | (acc & is_halt) | (in_rd & in_empty & in_eof);
    assign halt     = halt_q;

    assign mem_we   = acc & ~load & ~is_io;
    assign mem_in   = is_io ? '0 : data_out;
    assign addr_out = addr;

    assign in_ready  = ~in_full & rst_n;
    assign out_valid = ~out_empty;

    always_comb begin
        data_in = '0;
        if (!is_io)     data_in = mem_out;
        else if (in_pop) data_in = in_head;
`ifdef MMIO_STATUS_EN
        else if (acc && load && is_stat) begin
            data_in[STAT_IN_NEMPTY] = ~in_empty;
            data_in[STAT_OUT_NFULL] = ~out_full;
            data_in[STAT_IN_EOF]    = in_eof;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else        halt_q <= halt_d;
    end

    sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_push),
        .data_i  (in_data),
        .pop_i   (in_pop),
        .head_o  (in_head),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (out_push),
        .data_i  (data_out),
        .pop_i   (out_pop),
        .head_o  (out_data),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

endmodule

// File: tb/tb_mmio_stream.sv
// Directed bench for mmio_stream: stream FIFOs, stalls, halt and memory pass-through.
module tb_mmio_stream;

    localparam logic [15:0] TOP   = 16'hFFFF;
    localparam logic [15:0] A_OUT = 16'hFFFE;
    localparam logic [15:0] A_IN  = 16'hFFFD;
    localparam logic [15:0] A_ST  = 16'hFFFC;

    logic        clk = 1'b0;
    logic        rst_n, req, load, in_valid, in_eof, out_ready;
    logic [15:0] addr, data_out, mem_out, in_data;
    logic [15:0] data_in, mem_in, addr_out, out_data;
    logic        stall, halt, mem_we, in_ready, out_valid;

    int n_checks = 0;
    int n_errors = 0;

    mmio_stream dut (
        .clk(clk), .rst_n(rst_n), .req(req), .load(load), .addr(addr),
        .data_out(data_out), .data_in(data_in), .stall(stall), .halt(halt),
        .mem_out(mem_out), .mem_in(mem_in), .mem_we(mem_we), .addr_out(addr_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eof(in_eof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Commit the current cycle and return to the next negedge, where inputs change.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access(input logic ld, input logic [15:0] a, input logic [15:0] d);
        req = 1'b1; load = ld; addr = a; data_out = d;
        #1;
    endtask

    task automatic idle();
        req = 1'b0; load = 1'b0; addr = 16'h0000; data_out = 16'h0000;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_halt", halt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_rel", in_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; load = 1'b0; addr = '0; data_out = '0;
        mem_out = 16'hBEEF; in_valid = 1'b0; in_data = '0; in_eof = 1'b0; out_ready = 1'b0;
        #2;
        do_reset();

        // Two stream words read back in order without stalling
        in_valid = 1'b1; in_data = 16'h0041; step();
        in_data = 16'h0042; step();
        in_valid = 1'b0;
        access(1'b1, A_IN, 16'h0);
        chk("in_rd1", data_in, 16'h0041);
        chk("in_rd1_stall", stall, 1'b0);
        step();
        #1;
        chk("in_rd2", data_in, 16'h0042);
        chk("in_rd2_stall", stall, 1'b0);
        step();

        // Empty input without eof stalls until a word lands, one extra cycle for the push
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("in_stall%0d", i), stall, 1'b1);
            step();
        end
        in_valid = 1'b1; in_data = 16'h0007;
        #1;
        chk("in_stall_push", stall, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        chk("in_after_stall", stall, 1'b0);
        chk("in_after_data", data_in, 16'h0007);
        step();
        idle();

        // Output FIFO fill, full-stall even with out_ready, then in-order drain
        for (int k = 1; k <= 4; k++) begin
            access(1'b0, A_OUT, 16'(k));
            chk($sformatf("out_wr%0d_stall", k), stall, 1'b0);
            chk($sformatf("out_wr%0d_we", k), mem_we, 1'b0);
            step();
        end
        out_ready = 1'b1;
        access(1'b0, A_OUT, 16'd5);
        chk("out_full_stall", stall, 1'b1);
        chk("out_head1", out_data, 16'd1);
        step();
        #1;
        chk("out_wr5_stall", stall, 1'b0);
        chk("out_head2", out_data, 16'd2);
        step();
        idle();
        for (int k = 3; k <= 5; k++) begin
            chk($sformatf("out_valid%0d", k), out_valid, 1'b1);
            chk($sformatf("out_head%0d", k), out_data, 16'(k));
            step();
            #1;
        end
        chk("out_drained", out_valid, 1'b0);
        out_ready = 1'b0;

        // Memory pass-through and dead io reads
        access(1'b0, 16'h0010, 16'h1234);
        chk("mem_we", mem_we, 1'b1);
        chk("mem_in", mem_in, 16'h1234);
        chk("addr_out", addr_out, 16'h0010);
        step();
        access(1'b1, 16'h0010, 16'h0);
        chk("mem_rd", data_in, 16'hBEEF);
        chk("mem_rd_we", mem_we, 1'b0);
        step();
        access(1'b1, A_OUT, 16'h0);
        chk("rd_out_reg", data_in, 16'h0000);
        step();
        idle();
        chk("no_halt_yet", halt, 1'b0);

        // Status word with one input word and a full output FIFO, then reset mid-transfer
        in_valid = 1'b1; in_data = 16'h00AA; step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            access(1'b0, A_OUT, 16'(16'h50 + k));
            step();
        end
`ifdef MMIO_STATUS_EN
        access(1'b1, A_ST, 16'h0);
        chk("status", data_in, 16'h0001);
        chk("status_we", mem_we, 1'b0);
`else
        access(1'b0, A_ST, 16'h5555);
        chk("st_is_mem_we", mem_we, 1'b1);
        chk("st_is_mem_in", mem_in, 16'h5555);
`endif
        step();
        idle();
        chk("pre_rst_out_valid", out_valid, 1'b1);
        do_reset();
        chk("post_rst_out_valid", out_valid, 1'b0);

        // eof on an empty input halts; later accesses have no effect
        in_eof = 1'b1;
        access(1'b1, A_IN, 16'h0);
        chk("eof_data", data_in, 16'h0000);
        chk("eof_stall", stall, 1'b0);
        chk("eof_halt_early", halt, 1'b0);
        step();
        in_eof = 1'b0;
        access(1'b0, A_OUT, 16'h0099);
        chk("eof_halt", halt, 1'b1);
        chk("halted_stall", stall, 1'b0);
        step();
        access(1'b0, 16'h0020, 16'h7777);
        chk("halted_mem_we", mem_we, 1'b0);
        chk("halted_no_push", out_valid, 1'b0);
        step();
        idle();

        // Write to TOP halts the cycle after, without touching memory
        do_reset();
        access(1'b0, TOP, 16'h1111);
        chk("top_we", mem_we, 1'b0);
        chk("top_mem_in", mem_in, 16'h0000);
        chk("top_halt_early", halt, 1'b0);
        step();
        idle();
        chk("top_halt", halt, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
